// File: rtl/axi4s_video_pkg.sv
// -----------------------------------------------------------------------------
// axi4s_video_pkg
//   Shared definitions for the AXI4-Stream video pattern checker:
//   - state_t        : checker lock state (SYNC = hunting for SOF, RUN = locked)
//   - coord_w()      : register width for a coordinate counter with n positions
//   - expected_tdata(): pattern word {y, x}, each coordinate zero-extended or
//                       truncated to half the tdata width
//   Widths up to MAX_DATA_W (128) are supported by the helper.
// -----------------------------------------------------------------------------
package axi4s_video_pkg;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned MAX_HALF_W = 64;
  localparam int unsigned MAX_DATA_W = 2 * MAX_HALF_W;

  // Counter width for a coordinate taking values 0..n-1 (at least 1 bit).
  function automatic int unsigned coord_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Low half_w bits carry x, the next half_w bits carry y; upper bits are zero.
  function automatic logic [MAX_DATA_W-1:0] expected_tdata(
    input int unsigned           half_w,
    input logic [MAX_HALF_W-1:0] x,
    input logic [MAX_HALF_W-1:0] y
  );
    logic [MAX_DATA_W-1:0] mask;
    logic [MAX_DATA_W-1:0] xe;
    logic [MAX_DATA_W-1:0] ye;
    mask = (MAX_DATA_W'(1) << half_w) - MAX_DATA_W'(1);
    xe   = MAX_DATA_W'(x) & mask;
    ye   = (MAX_DATA_W'(y) & mask) << half_w;
    return xe | ye;
  endfunction

endpackage

// File: rtl/axi4s_checker_lfsr16.sv
// -----------------------------------------------------------------------------
// axi4s_checker_lfsr16
//   16-bit Galois LFSR (taps 0xB400, maximal length) used to generate
//   pseudo-random backpressure. Steps every cycle; loaded with SEED in reset.
//   ready is low whenever the two LSBs are both zero (about one cycle in four).
// Ports:
//   aclk     in   clock
//   aresetn  in   synchronous active-low reset
//   ready    out  combinational ready request (registered by the parent)
// -----------------------------------------------------------------------------
module axi4s_checker_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic aclk,
  input  logic aresetn,
  output logic ready
);

  logic [15:0] lfsr_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign ready = |lfsr_q[1:0];

endmodule

// File: rtl/axi4s_video_checker.sv
// -----------------------------------------------------------------------------
// axi4s_video_checker
//   AXI4-Stream sink for the video test pattern. Tracks the expected (x, y)
//   position of every accepted beat and checks tuser (SOF at (0,0)), tlast
//   (EOL at x == X_NUM-1) and tdata ({y, x}). Counts completed frames and
//   the three error classes with saturating counters.
//   Optional build macro CHECKER_BACKPRESSURE_EN: tready follows a 16-bit LFSR
//   (~25% stall); otherwise tready is held high after reset.
// Ports:
//   aclk, aresetn     clock, synchronous active-low reset
//   s_axi4s_tuser     start of frame
//   s_axi4s_tlast     end of line
//   s_axi4s_tdata     pixel {y, x}
//   s_axi4s_tvalid    beat valid
//   s_axi4s_tready    registered ready
//   frame_count       completed frames (wraps)
//   frame_done        one-cycle pulse per completed frame
//   err_sof/eol/data  saturating error counters
//   err_any           any error counter non-zero
//   in_sync           checker locked to the stream
// -----------------------------------------------------------------------------
module axi4s_video_checker
  import axi4s_video_pkg::*;
#(
  parameter int unsigned  AXI4S_DATA_WIDTH = 32,
  parameter int unsigned  X_NUM            = 640,
  parameter int unsigned  Y_NUM            = 480,
  parameter int unsigned  ERR_WIDTH        = 16,
  parameter int unsigned  FRAME_WIDTH      = 32,
  parameter logic [15:0]  LFSR_SEED        = 16'hACE1
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        s_axi4s_tuser,
  input  logic                        s_axi4s_tlast,
  input  logic [AXI4S_DATA_WIDTH-1:0] s_axi4s_tdata,
  input  logic                        s_axi4s_tvalid,
  output logic                        s_axi4s_tready,
  output logic [FRAME_WIDTH-1:0]      frame_count,
  output logic                        frame_done,
  output logic [ERR_WIDTH-1:0]        err_sof,
  output logic [ERR_WIDTH-1:0]        err_eol,
  output logic [ERR_WIDTH-1:0]        err_data,
  output logic                        err_any,
  output logic                        in_sync
);

  localparam int unsigned HALF_W = AXI4S_DATA_WIDTH / 2;
  localparam int unsigned XW     = coord_w(X_NUM);
  localparam int unsigned YW     = coord_w(Y_NUM);
  localparam logic [XW-1:0] X_LAST = XW'(X_NUM - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(Y_NUM - 1);

  if ((AXI4S_DATA_WIDTH % 2) != 0 || AXI4S_DATA_WIDTH > MAX_DATA_W ||
      X_NUM < 2 || Y_NUM < 1 || LFSR_SEED == 16'h0000) begin : g_param_err
    $error("axi4s_video_checker: illegal parameter combination");
  end

  function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
    return (&v) ? v : v + ERR_WIDTH'(1);
  endfunction

  state_t          state, state_nxt;
  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic            tready_q;
  logic            ready_src;

  logic            accept, take, at_origin, resync;
  logic [XW-1:0]   eff_x;
  logic [YW-1:0]   eff_y;
  logic            line_end, frame_end;
  logic            sof_bad, eol_bad, data_bad;
  logic [MAX_DATA_W-1:0] tdata_ext;

`ifdef CHECKER_BACKPRESSURE_EN
  axi4s_checker_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .aclk    (aclk),
    .aresetn (aresetn),
    .ready   (ready_src)
  );
`else
  assign ready_src = 1'b1;
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) tready_q <= 1'b0;
    else          tready_q <= ready_src;
  end

  assign s_axi4s_tready = tready_q;

  // Beat decode: SYNC only takes a beat carrying tuser; a tuser away from the
  // origin restarts the position at (0,0) before the beat is checked.
  assign accept    = s_axi4s_tvalid & tready_q;
  assign take      = accept & ((state == RUN) | s_axi4s_tuser);
  assign at_origin = (x_q == '0) && (y_q == '0);
  assign resync    = s_axi4s_tuser & ~at_origin;
  assign eff_x     = resync ? '0 : x_q;
  assign eff_y     = resync ? '0 : y_q;
  assign line_end  = (eff_x == X_LAST);
  assign frame_end = line_end && (eff_y == Y_LAST);
  assign tdata_ext = MAX_DATA_W'(s_axi4s_tdata);

  assign sof_bad  = take & (state == RUN) & (s_axi4s_tuser != at_origin);
  assign eol_bad  = take & (s_axi4s_tlast != line_end);
  assign data_bad = take &
    (tdata_ext != expected_tdata(HALF_W, MAX_HALF_W'(eff_x), MAX_HALF_W'(eff_y)));

  // FSM: state register
  always_ff @(posedge aclk) begin
    if (!aresetn) state <= SYNC;
    else          state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    if (state == SYNC && accept && s_axi4s_tuser) state_nxt = RUN;
  end

  // FSM: outputs
  always_comb begin
    in_sync = (state == RUN);
  end

  // Position tracking and counters, updated the cycle after an accepted beat
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      x_q         <= '0;
      y_q         <= '0;
      frame_count <= '0;
      frame_done  <= 1'b0;
      err_sof     <= '0;
      err_eol     <= '0;
      err_data    <= '0;
      err_any     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (take) begin
        if (line_end) begin
          x_q <= '0;
          if (frame_end) begin
            y_q         <= '0;
            frame_count <= frame_count + FRAME_WIDTH'(1);
            frame_done  <= 1'b1;
          end else begin
            y_q <= eff_y + YW'(1);
          end
        end else begin
          x_q <= eff_x + XW'(1);
          y_q <= eff_y;
        end
        if (sof_bad)  err_sof  <= sat_inc(err_sof);
        if (eol_bad)  err_eol  <= sat_inc(err_eol);
        if (data_bad) err_data <= sat_inc(err_data);
        err_any <= err_any | sof_bad | eol_bad | data_bad;
      end
    end
  end

endmodule
